// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, S-box tables, GF helpers and key-size arithmetic.
package aes_pkg;
   typedef logic [7:0] byte_t;
   typedef logic [31:0] word_t;
   typedef logic [127:0] state_t;
   typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} fsm_t;
   localparam byte_t RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
   // table entry b sits at bit 8*(255-b)+7, i.e. {~b, 3'b111}
   function automatic byte_t sbox(input byte_t b);
      return SBOX[{~b, 3'b111} -: 8];
   endfunction
   function automatic byte_t inv_sbox(input byte_t b);
      return INV_SBOX[{~b, 3'b111} -: 8];
   endfunction
   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic word_t sub_word(input word_t w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction
   function automatic word_t mix_col(input word_t a);
      byte_t a0, a1, a2, a3, t;
      {a0, a1, a2, a3} = a;
      t = a0 ^ a1 ^ a2 ^ a3;
      return {a0 ^ t ^ xtime(a0 ^ a1), a1 ^ t ^ xtime(a1 ^ a2), a2 ^ t ^ xtime(a2 ^ a3), a3 ^ t ^ xtime(a3 ^ a0)};
   endfunction
   // InvMixColumns factored as a cheap pre-multiply followed by MixColumns
   function automatic word_t inv_mix_col(input word_t a);
      byte_t u, v;
      u = xtime(xtime(a[31:24] ^ a[15:8]));
      v = xtime(xtime(a[23:16] ^ a[7:0]));
      return mix_col(a ^ {u, v, u, v});
   endfunction
   function automatic logic [3:0] nk2nr(input logic [3:0] nk);
      return nk + 4'd6;
   endfunction
   function automatic logic [5:0] nk2words(input logic [3:0] nk);
      return 6'({nk2nr(nk), 2'b00}) + 6'd4 - 6'(nk);
   endfunction
endpackage

// File: rtl/aes_iter_core_if.sv
// aes_iter_core_if: request/response handshake bundle between block buffer, AES core and output formatter.
interface aes_iter_core_if #(parameter int NK_MAX = 8);
   logic in_valid, in_ready, decrypt, key_reuse, out_valid, out_ready, nk_err;
   logic [127:0] text, result;
   logic [32*NK_MAX-1:0] key;
   logic [3:0] nk;
   modport master (output in_valid, text, key, nk, decrypt, key_reuse, out_ready,
                   input in_ready, out_valid, result, nk_err);
   modport slave (input in_valid, text, key, nk, decrypt, key_reuse, out_ready,
                  output in_ready, out_valid, result, nk_err);
endinterface

// File: rtl/aes_round.sv
// aes_round: one combinational AES round; the inverse round is present only with AES_ITER_DECRYPT_EN.
module aes_round
   import aes_pkg::*;
(
   input state_t st,
   input state_t rk,
   input logic dec,
   input logic last,
   output state_t nxt
);
   state_t sb, mc, enxt;
   // byte i is row i%4, column i/4; ShiftRows pulls row r from column c+r
   for (genvar i = 0; i < 16; i++) begin : g_fwd
      assign sb[127-8*i -: 8] = sbox(st[127-8*((i % 4) + 4*(((i / 4) + (i % 4)) % 4)) -: 8]);
   end
   for (genvar c = 0; c < 4; c++) begin : g_mix
      assign mc[127-32*c -: 32] = mix_col(sb[127-32*c -: 32]);
   end
   assign enxt = (last ? sb : mc) ^ rk;
`ifdef AES_ITER_DECRYPT_EN
   state_t ib, ark, im;
   for (genvar i = 0; i < 16; i++) begin : g_inv
      assign ib[127-8*i -: 8] = inv_sbox(st[127-8*((i % 4) + 4*(((i / 4) + 4 - (i % 4)) % 4)) -: 8]);
   end
   assign ark = ib ^ rk;
   for (genvar c = 0; c < 4; c++) begin : g_imix
      assign im[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
   end
   assign nxt = dec ? (last ? ark : im) : enxt;
`else
   logic unused_dec;
   assign unused_dec = dec;
   assign nxt = enxt;
`endif
endmodule

// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128/192/256 engine, one round per clock, with a cached key schedule.
// Define AES_ITER_DECRYPT_EN to compile in the inverse cipher; otherwise every request encrypts.
module aes_iter_core
   import aes_pkg::*;
#(
   parameter int NK_MAX = 8
) (
   input logic clk,
   input logic rst,
   aes_iter_core_if.slave bus
);
   localparam int WORDS = 4 * (NK_MAX + 7);
   localparam int AW = $clog2(WORDS);
   fsm_t fsm;
   word_t w [WORDS];
   word_t w_prev, w_back, w_sub, w_tmp, new_w;
   state_t st, rk, rk_entry, nxt;
   logic [3:0] nk_q, nr_q, nr_in, cache_nk, rnd, ridx, kr;
   logic [2:0] kpos;
   logic [AW-1:0] wi, kb, last_w;
   logic dec_q, dec_in, cache_vld, out_valid, nk_err, accept, nk_ok, reuse_ok;
`ifdef AES_ITER_DECRYPT_EN
   assign dec_in = bus.decrypt;
`else
   logic unused_decrypt;
   assign unused_decrypt = bus.decrypt;
   assign dec_in = 1'b0;
`endif
   assign accept = bus.in_valid && bus.in_ready;
   assign nr_in = nk2nr(bus.nk);
   assign nk_ok = (bus.nk == 4'd4 || bus.nk == 4'd6 || bus.nk == 4'd8) && int'(bus.nk) <= NK_MAX;
   assign reuse_ok = bus.key_reuse && cache_vld && bus.nk == cache_nk;
   // round-key index: entry whitening key while idle/expanding, then the per-round key
   assign kr = (fsm == IDLE) ? (dec_in ? nr_in : 4'd0) :
               (fsm == KEXP) ? (dec_q ? nr_q : 4'd0) : (dec_q ? nr_q - rnd : rnd);
   assign kb = AW'({kr, 2'b00});
   assign rk = {w[kb], w[kb+1], w[kb+2], w[kb+3]};
   // the last word of round key Nr is still being produced on the final expansion cycle
   assign rk_entry = {rk[127:32], dec_q ? new_w : rk[31:0]};
   assign w_prev = w[wi - 1'b1];
   assign w_back = w[wi - AW'(nk_q)];
   assign w_sub = sub_word(kpos == 3'd0 ? {w_prev[23:0], w_prev[31:24]} : w_prev);
   assign w_tmp = (kpos == 3'd0) ? w_sub ^ {RCON[ridx], 24'd0} :
                  (nk_q == 4'd8 && kpos == 3'd4) ? w_sub : w_prev;
   assign new_w = w_back ^ w_tmp;
   assign last_w = AW'(6'(nk_q) + nk2words(nk_q) - 6'd1);
   aes_round u_round (.st(st), .rk(rk), .dec(dec_q), .last(rnd == nr_q), .nxt(nxt));
   always_ff @(posedge clk)
      if (accept && nk_ok && !reuse_ok) begin
         for (int j = 0; j < NK_MAX; j++)
            if (j < int'(bus.nk)) w[j] <= bus.key[32*(int'(bus.nk)-1-j) +: 32];
      end else if (fsm == KEXP) w[wi] <= new_w;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         fsm <= IDLE;
         st <= '0;
         out_valid <= 1'b0;
         nk_err <= 1'b0;
         cache_vld <= 1'b0;
         cache_nk <= '0;
         rnd <= '0;
         nk_q <= '0;
         nr_q <= '0;
         dec_q <= 1'b0;
         wi <= '0;
         kpos <= '0;
         ridx <= '0;
      end else case (fsm)
         IDLE: if (accept) begin
            nk_q <= bus.nk;
            nr_q <= nr_in;
            dec_q <= dec_in;
            rnd <= 4'd1;
            wi <= AW'(bus.nk);
            kpos <= '0;
            ridx <= '0;
            nk_err <= !nk_ok;
            if (!nk_ok) begin
               st <= '0;
               out_valid <= 1'b1;
               fsm <= DONE;
            end else if (reuse_ok) begin
               st <= bus.text ^ rk;
               fsm <= ROUND;
            end else begin
               st <= bus.text;
               cache_vld <= 1'b0;
               fsm <= KEXP;
            end
         end
         KEXP: begin
            wi <= wi + 1'b1;
            kpos <= (kpos == 3'(nk_q - 4'd1)) ? 3'd0 : kpos + 3'd1;
            ridx <= ridx + 4'(kpos == 3'd0);
            if (wi == last_w) begin
               st <= st ^ rk_entry;
               cache_vld <= 1'b1;
               cache_nk <= nk_q;
               fsm <= ROUND;
            end
         end
         ROUND: begin
            st <= nxt;
            rnd <= rnd + 4'd1;
            if (rnd == nr_q) begin
               out_valid <= 1'b1;
               fsm <= DONE;
            end
         end
         DONE: if (bus.out_ready) begin
            out_valid <= 1'b0;
            fsm <= IDLE;
         end
      endcase
   assign bus.in_ready = fsm == IDLE && !rst;
   assign bus.out_valid = out_valid;
   assign bus.result = st;
   assign bus.nk_err = nk_err;
endmodule

// File: doc/aes_iter_core.md
# aes_iter_core

Iterative, multi-key-size AES engine that replaces the fully unrolled combinational encrypt/decrypt top with one registered round per clock. It runs a single key schedule for AES-128, AES-192 and AES-256, selected per block by `Nk`. Encryption and decryption are selected per block, and results are returned through a valid/ready handshake. It sits between the host-side block buffer and the output formatter, and can reuse a cached key schedule across consecutive blocks.

## Interface
- `NK_MAX`, default 8: largest supported Nk (4, 6 or 8).
  - Sizes `Key` to 32·NK_MAX bits.
  - Sizes the round-key store to 4·(NK_MAX+7) words.
- `Clk` in 1: single clock, rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `InValid` in 1: request present.
- `InReady` out 1: engine idle and able to accept a request.
- `Text` in 128: input block; `Text[127:120]` is byte 0.
- `Key` in 32·NK_MAX: cipher key, low-aligned.
  - Nk=4 uses `Key[127:0]`, Nk=6 uses `Key[191:0]`, Nk=8 uses `Key[255:0]`.
  - Word w0 is the top 32 bits of the used field.
- `Nk` in 4: key length in words.
- `Decrypt` in 1: 1 = inverse cipher, 0 = forward cipher.
- `KeyReuse` in 1: skip key expansion and use the cached schedule.
- `OutValid` out 1: result available.
- `OutReady` in 1: consumer accepts the result.
- `Result` out 128: output block.
- `NkErr` out 1: qualifies `Result`; request carried an unsupported Nk.

## Operation
- FSM states: IDLE, KEXP, ROUND, DONE.
- IDLE: `InReady`=1 (forced 0 while `Rst` is high).
- Accept happens when `InValid`&&`InReady`. On accept:
  - Latch `Nk` and `Decrypt`; Nr = Nk+6.
  - Unsupported Nk (not 4, 6 or 8, or greater than NK_MAX): go to DONE with `Result`=0 and `NkErr`=1. The cached schedule is left untouched.
  - `KeyReuse`=1, cache valid and Nk equal to the cached Nk: load state and go to ROUND.
  - Otherwise load the key words w0..w(Nk−1) into the store and go to KEXP. `KeyReuse` with an invalid or mismatched cache is silently treated as 0.
- KEXP: computes one word per cycle, w[i] for i=Nk..4(Nr+1)−1.
  - Standard RotWord/SubWord/Rcon rule.
  - Extra SubWord when Nk=8 and i mod 8 = 4.
  - Word counts: 40 (Nk=4), 46 (Nk=6), 52 (Nk=8).
  - On completion, cache valid is set to 1 and the cached Nk is recorded.
- ROUND, entry: state = Text XOR round key 0 (encrypt) or round key Nr (decrypt).
- ROUND, each cycle: one full round from sub-module `aes_round`.
  - Encrypt: SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - Decrypt: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
  - The final round omits (Inv)MixColumns.
  - Round counter runs 1..Nr. Decrypt indexes keys Nr−r.
- DONE: `OutValid`=1 and `Result` held stable until `OutReady`. On `OutValid`&&`OutReady` go to IDLE next cycle.
- `InReady`=0 in every state except IDLE, so there is no accept overlap with an undelivered result.
- Reset values: state IDLE, `OutValid`=0, `Result`=0, `NkErr`=0, cache valid 0, round counter 0, `InReady`=0 while `Rst` is asserted.
- Reset asserted mid-KEXP or mid-ROUND aborts the block. Nothing is emitted, and the cache is invalidated.

## Timing
- Accept at cycle T; W = number of expansion words (0 when the cache is reused).
- ROUND occupies T+W+1..T+W+Nr. `OutValid` rises at T+W+Nr+1.
- Full-expansion latency: AES-128 51, AES-192 59, AES-256 67 cycles.
- Cached-key latency: 11, 13 and 15 cycles respectively.
- NkErr response: `OutValid` at T+1.
- Earliest next accept: the cycle after the output handshake.
- Critical path: one S-box layer + MixColumns + XOR per cycle for rounds; one S-box word + XOR for KEXP.

## Configuration
- `AES_ITER_DECRYPT_EN` defined:
  - Inverse round logic and inverse S-box are compiled in.
  - `Decrypt` is honoured.
- `AES_ITER_DECRYPT_EN` undefined:
  - Only forward logic is present.
  - `Decrypt` is ignored and every request encrypts.
  - Latencies are unchanged.

## Structure
- Package `aes_pkg` holds:
  - Forward/inverse S-box functions, `xtime`, and the Rcon table (10 entries).
  - The FSM state enum.
  - An Nk-to-Nr function and an Nk-to-word-count function.
  - Byte/word/state type definitions.
- Sub-module `aes_round` is combinational: state, round key, decrypt flag and last-round flag in; next state out. It is instantiated once.
- The key store is a register file of 4·(NK_MAX+7) 32-bit words inside the top. Key expansion uses one 4-byte S-box lane.

## Test plan
- AES-128: Key[127:0]=000102…0f, Text=00112233445566778899aabbccddeeff, encrypt → Result=69c4e0d86a7b0430d8cdb78070b4c55a, `OutValid` at T+51.
- AES-192 key 000102…17 → dda97ca4864cdfe06eaf70a0ec0d7191 at T+59; AES-256 key 000102…1f → 8ea2b7ca516745bfeafc49904b496089 at T+67.
- Decrypt each ciphertext above with the same key → 00112233445566778899aabbccddeeff. A second block with `KeyReuse`=1 returns at T+11 / T+13 / T+15.
- Nk=5 → `Result`=0, `NkErr`=1 at T+1, and the cache is still valid: a following reuse request with Nk=4 is still fast.
- Hold `OutReady`=0 for 20 cycles → `Result` stable and `InReady`=0 throughout. Assert `Rst` mid-ROUND → `OutValid` stays 0, and the next `KeyReuse`=1 request performs full expansion.
- Build without `AES_ITER_DECRYPT_EN`: `Decrypt`=1 with the AES-128 vector → 69c4e0d86a7b0430d8cdb78070b4c55a.
